// File: rtl/key_event_pkg.sv
// Shared constants, counter action encoding and seven-segment decode
// for the front-panel key event counter.
package key_event_pkg;

  localparam int NUM_KEYS = 3;
  localparam int KEY_STEP = 0;
  localparam int KEY_LOAD = 1;
  localparam int KEY_CLR  = 2;

  // Active-low segments, bit order g..a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_STEP,
    ACT_LOAD,
    ACT_CLR
  } action_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    for (int i = 0; i < 16; i++) begin
      if (nib == 4'(i)) seg = SEG_TABLE[i];
    end
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser, debounce counter and a
// registered one-cycle pulse on each debounced press (1 -> 0).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q;
  logic          stable_d;
  logic          prev_q;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Edge detect on the registered stable level so the pulse trails the flip by a cycle
  assign press_d = prev_q & ~stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      meta_q   <= raw_n_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/key_event_counter.sv
// DE1 front-panel counter: debounced KEY[2:0] drive a clear/load/step
// counter shown on the hex displays and the red LEDs.
module key_event_counter
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 8,
  parameter int NUM_DIGITS      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              key_n,
  input  logic [9:0]              sw,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [9:0]              ledr
);

  localparam int SW_WRAP = 8;
  localparam int SW_DOWN = 9;
  localparam int HEX_W   = NUM_DIGITS * 4;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [9:0]           sw_meta_q;
  logic [9:0]           sw_sync_q;
  logic [NUM_KEYS-1:0]  press;
  action_e              action;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 limit_q;
  logic                 limit_d;
  logic                 strobe_q;
  logic                 strobe_d;
  logic [HEX_W-1:0]     count_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '1;
      sw_sync_q <= '1;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_n_i (key_n[gi]),
        .press_o (press[gi])
      );
    end
  endgenerate

  // Coincident presses: only the highest-priority one is acted on
  always_comb begin
    action = ACT_NONE;
    if (press[KEY_CLR]) begin
      action = ACT_CLR;
    end else if (press[KEY_LOAD]) begin
      action = ACT_LOAD;
    end else if (press[KEY_STEP]) begin
      action = ACT_STEP;
    end
  end

  always_comb begin
    count_d  = count_q;
    limit_d  = limit_q;
    strobe_d = 1'b0;
    unique case (action)
      ACT_CLR: begin
        count_d  = '0;
        limit_d  = 1'b0;
        strobe_d = 1'b1;
      end
      ACT_LOAD: begin
        count_d  = CNT_WIDTH'(sw_sync_q[7:0]);
        strobe_d = 1'b1;
      end
      ACT_STEP: begin
        strobe_d = 1'b1;
        if (sw_sync_q[SW_DOWN]) begin
          if (count_q == '0) begin
            limit_d = 1'b1;
            if (sw_sync_q[SW_WRAP]) count_d = CNT_MAX;
          end else begin
            count_d = count_q - CNT_WIDTH'(1);
          end
        end else begin
          if (count_q == CNT_MAX) begin
            limit_d = 1'b1;
            if (sw_sync_q[SW_WRAP]) count_d = '0;
          end else begin
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      limit_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      limit_q  <= limit_d;
      strobe_q <= strobe_d;
    end
  end

  assign count_ext = HEX_W'(count_q);

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [6:0] seg_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seg_q <= SEG_TABLE[0];
        end else begin
          seg_q <= hex_to_seg(count_ext[4*gi +: 4]);
        end
      end
      assign hex[7*gi +: 7] = seg_q;
    end
  endgenerate

  assign ledr = {strobe_q, limit_q, 8'(count_q)};

endmodule

// File: tb/tb_key_event_counter.sv
// Randomised bench for key_event_counter against a cycle-indexed reference
// model built from the input history and the documented timing rules.
module tb_key_event_counter;

  localparam int DB   = 4;
  localparam int CW   = 8;
  localparam int ND   = 2;
  localparam int MAXV = 255;
  localparam int HIST = 16384;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    key_n = 3'b111;
  logic [9:0]    sw = 10'h000;
  logic [7*ND-1:0] hex;
  logic [9:0]    ledr;

  key_event_counter #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH      (CW),
    .NUM_DIGITS     (ND)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .sw    (sw),
    .hex   (hex),
    .ledr  (ledr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Reference state: input samples per clock edge and the derived events
  logic [2:0] key_hist [HIST];
  logic [9:0] sw_hist  [HIST];
  int         edge_no  = 0;
  int         rel_edge = 0;
  int         flip_edge [3];
  int         run [3];
  logic [2:0] stable;
  logic [7:0] m_cnt, m_hex_cnt;
  logic       m_lim, m_strobe;

  task automatic model_reset();
    m_cnt = 8'd0; m_hex_cnt = 8'd0; m_lim = 1'b0; m_strobe = 1'b0;
    stable = 3'b111;
    for (int k = 0; k < 3; k++) begin
      run[k] = 0;
      flip_edge[k] = -100;
    end
  endtask

  // A press takes effect two edges after the key's stable level falls;
  // the stable level falls once the synchronised key (raw two edges ago)
  // has differed from it on DB consecutive edges.
  task automatic model_step();
    logic [2:0] ev;
    logic [2:0] s;
    logic [9:0] swv;
    int nxt;
    key_hist[edge_no] = key_n;
    sw_hist[edge_no]  = sw;
    for (int k = 0; k < 3; k++) ev[k] = (flip_edge[k] == edge_no - 2);
    m_hex_cnt = m_cnt;
    m_strobe  = (ev != 3'b000);
    swv = (edge_no >= 2) ? sw_hist[edge_no - 2] : 10'h000;
    if (ev[2]) begin
      m_cnt = 8'd0;
      m_lim = 1'b0;
    end else if (ev[1]) begin
      m_cnt = swv[7:0];
    end else if (ev[0]) begin
      nxt = int'(m_cnt) + (swv[9] ? -1 : 1);
      if (nxt < 0 || nxt > MAXV) begin
        m_lim = 1'b1;
        if (swv[8]) nxt = (nxt < 0) ? MAXV : 0;
        else        nxt = int'(m_cnt);
      end
      m_cnt = 8'(nxt);
    end
    s = (edge_no - 2 >= rel_edge) ? key_hist[edge_no - 2] : 3'b111;
    for (int k = 0; k < 3; k++) begin
      if (s[k] != stable[k]) begin
        run[k]++;
        if (run[k] == DB) begin
          stable[k] = s[k];
          run[k] = 0;
          if (!stable[k]) flip_edge[k] = edge_no;
        end
      end else begin
        run[k] = 0;
      end
    end
    edge_no++;
  endtask

  task automatic cyc(input logic [2:0] kn, input logic [9:0] s);
    key_n = kn;
    sw    = s;
    @(posedge clk);
    model_step();
    #1;
    chk("ledr", 32'(ledr), 32'({m_strobe, m_lim, m_cnt}));
    chk("hex", 32'(hex), 32'({seg(m_hex_cnt[7:4]), seg(m_hex_cnt[3:0])}));
  endtask

  task automatic press_key(input logic [2:0] kn, input logic [9:0] s, input int hold, input int rel);
    repeat (hold) cyc(kn, s);
    repeat (rel) cyc(3'b111, s);
  endtask

  // Called just after a sampling point; outputs must clear without a clock edge
  task automatic do_reset(input logic [2:0] kn_during);
    rst_n = 1'b0;
    key_n = kn_during;
    model_reset();
    #1;
    chk("rst_ledr", 32'(ledr), 32'd0);
    chk("rst_hex", 32'(hex), 32'({7'b1000000, 7'b1000000}));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel_edge = edge_no;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ledr", 32'(ledr), 32'd0);
    chk("rst_hex", 32'(hex), 32'({7'b1000000, 7'b1000000}));
    rst_n = 1'b1;
    rel_edge = edge_no;
    repeat (10) cyc(3'b111, 10'h000);
    chk("idle_hex", 32'(hex), 32'({7'b1000000, 7'b1000000}));
    chk("idle_ledr", 32'(ledr), 32'd0);

    // Reset during a press; key released while reset is held
    repeat (3) cyc(3'b110, 10'h000);
    do_reset(3'b111);
    repeat (12) cyc(3'b111, 10'h000);
    chk("rst_press_cnt", 32'(ledr), 32'd0);

    // Latency: key low first sampled at edge E (i == 0)
    for (int i = 0; i < 20; i++) begin
      cyc(3'b110, 10'h000);
      if (i == 6) chk("lat_before", 32'(ledr[7:0]), 32'd0);
      if (i == 7) begin
        chk("lat_at", 32'(ledr[7:0]), 32'd1);
        chk("lat_strobe", 32'(ledr[9]), 32'd1);
      end
      if (i == 8) begin
        chk("strobe_end", 32'(ledr[9]), 32'd0);
        chk("hex_one", 32'(hex[6:0]), 32'(7'b1111001));
      end
    end
    chk("held_once", 32'(ledr[7:0]), 32'd1);
    repeat (6) cyc(3'b111, 10'h000);

    // Bounce shorter than the debounce window
    repeat (3) cyc(3'b110, 10'h000);
    cyc(3'b111, 10'h000);
    repeat (2) cyc(3'b110, 10'h000);
    repeat (10) cyc(3'b111, 10'h000);
    chk("bounce_hold", 32'(ledr[7:0]), 32'd1);
    press_key(3'b110, 10'h000, 8, 8);
    chk("clean_after", 32'(ledr[7:0]), 32'd2);

    // Load FE, wrap upward
    press_key(3'b101, 10'h1FE, 8, 8);
    chk("load_fe", 32'(ledr[7:0]), 32'hFE);
    chk("hex_fe", 32'(hex), 32'({7'b0001110, 7'b0000110}));
    press_key(3'b110, 10'h1FE, 8, 8);
    chk("step_ff", 32'(ledr[7:0]), 32'hFF);
    press_key(3'b110, 10'h1FE, 8, 8);
    chk("wrap_00", 32'(ledr[7:0]), 32'h00);
    chk("wrap_lim", 32'(ledr[8]), 32'd1);

    // Saturate downward at zero
    press_key(3'b011, 10'h200, 8, 8);
    chk("clr_lim", 32'(ledr[8]), 32'd0);
    press_key(3'b110, 10'h200, 8, 8);
    chk("sat_cnt", 32'(ledr[7:0]), 32'd0);
    chk("sat_lim", 32'(ledr[8]), 32'd1);
    press_key(3'b011, 10'h200, 8, 8);
    chk("clr_lim2", 32'(ledr[8]), 32'd0);

    // Coincident presses
    press_key(3'b101, 10'h005, 8, 8);
    chk("load_5", 32'(ledr[7:0]), 32'd5);
    press_key(3'b001, 10'h005, 8, 8);
    chk("clr_wins", 32'(ledr[7:0]), 32'd0);
    press_key(3'b100, 10'h010, 8, 8);
    chk("load_wins", 32'(ledr[7:0]), 32'h10);

    // Randomised presses with bounce, switch changes and occasional reset
    for (int t = 0; t < 80; t++) begin
      logic [2:0] mask;
      logic [9:0] s;
      int nb, hold, rel;
      s = 10'($urandom);
      mask = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 2) != 0) mask = 3'b001 << $urandom_range(0, 2);
      nb   = $urandom_range(0, 4);
      hold = $urandom_range(1, 10);
      rel  = $urandom_range(1, 10);
      for (int b = 0; b < nb; b++) cyc(~(mask & 3'($urandom)), s);
      repeat (hold) cyc(~mask, s);
      if (t % 16 == 9) do_reset(3'($urandom));
      for (int b = 0; b < rel; b++) begin
        if ($urandom_range(0, 5) == 0) cyc(~(mask & 3'($urandom)), s);
        else cyc(3'b111, s);
      end
    end
    repeat (10) cyc(3'b111, 10'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_event_counter.md
Name: key_event_counter

Overview:
- Parametrised DE1 front-panel counter: synchronises and debounces the push-buttons, turns each debounced press into a one-cycle event, and drives an up/down, loadable counter.
- Counter value is shown on NUM_DIGITS seven-segment displays and on the red LEDs.
- Sits directly under the board top level, between the raw KEY/SW pins and the HEX/LEDR pins.
- Replaces the earlier unclocked, KEY-driven test counter with a properly clocked, glitch-free block.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a key must differ from its stable level before the stable level flips; must be ≥ 1; benches use 4.
- CNT_WIDTH, 8: counter width in bits; range 1..16.
- NUM_DIGITS, 2: number of hex digits driven; NUM_DIGITS*4 must be ≥ CNT_WIDTH.

Ports:
- clk  in  1  system clock (50 MHz on the board).
- rst_n  in  1  asynchronous active-low reset (KEY[3] at top level).
- key_n  in  3  raw push-buttons KEY[2:0]; active-low; asynchronous to clk.
- sw  in  10  slide switches; asynchronous; synchronised internally.
  - sw[7:0]: load value.
  - sw[8]: 1 = wrap, 0 = saturate.
  - sw[9]: 1 = count down, 0 = count up.
- hex  out  7*NUM_DIGITS  active-low segments; digit i occupies [7i+6:7i], bit order g..a; digit 0 = least-significant nibble.
- ledr  out  10  status LEDs.
  - ledr[7:0]: count zero-extended/truncated to 8 bits.
  - ledr[8]: sticky limit flag.
  - ledr[9]: event strobe stretched to 1 cycle (registered).

Behaviour:
- Reset:
  - Reset is asserted when rst_n = 0, asynchronously; all flops clear immediately.
  - Register values in reset: count = 0; limit flag = 0; synchronisers = 1 (keys released); stable levels = 1; debounce counters = 0.
  - Outputs in reset: hex shows "0" on every digit (7'b1000000); ledr = 0.
  - Release is synchronous to clk.
  - Reset mid-debounce or mid-press discards the press; no event is produced on release unless the key goes high and is then pressed again.
- Synchronisation:
  - Two flops per key_n bit and per sw bit.
  - Synchronised sw is sampled at the moment an event is applied.
- Debounce, per key, independent:
  - While sync ≠ stable, the counter increments; when it reaches DEBOUNCE_CYCLES-1 and sync still ≠ stable, stable := sync and the counter clears.
  - Any cycle with sync == stable clears the counter.
  - Bounces shorter than DEBOUNCE_CYCLES never change stable.
- Events:
  - press[k] is a registered one-cycle pulse on a stable falling edge (1→0). Release produces nothing.
  - Holding a key yields exactly one event.
- Latency: the raw key_n low first sampled at edge E gives the count update at edge E + DEBOUNCE_CYCLES + 3.
- Counter actions, applied on the edge after the pulse. Priority when pulses coincide: KEY2 (clear) > KEY1 (load) > KEY0 (step); lower-priority simultaneous events are dropped.
  - clear: count := 0, limit flag := 0.
  - load: count := sw[7:0] resized to CNT_WIDTH (zero-extend or truncate).
  - step up:
    - At 2^CNT_WIDTH-1 with wrap: count := 0, limit flag := 1.
    - At 2^CNT_WIDTH-1 with saturate: count is held, limit flag := 1.
  - step down:
    - At 0 with wrap: count := all-ones, limit flag := 1.
    - At 0 with saturate: count is held, limit flag := 1.
  - The limit flag is sticky; only clear or reset lowers it. Load leaves it unchanged.
- Display:
  - Each hex digit is a registered decode of its nibble of the zero-extended count, 0-F (A b C d E F); 1 cycle after the count changes.
  - ledr[9] = 1 in the cycle the count register updates from any event.

Decomposition:
- Package key_event_pkg:
  - SEG_BLANK and the 16-entry active-low 7-segment table.
  - Key index constants KEY_STEP = 0, KEY_LOAD = 1, KEY_CLR = 2.
  - Enum for the counter action {ACT_NONE, ACT_STEP, ACT_LOAD, ACT_CLR}.
  - Function hex_to_seg.
- Sub-module key_debounce (params DEBOUNCE_CYCLES): clk, rst_n, raw_n → press pulse. Instantiated 3× via generate.

Test Plan (DEBOUNCE_CYCLES = 4, CNT_WIDTH = 8, NUM_DIGITS = 2):
- Reset then idle 10 cycles → hex = {7'b1000000, 7'b1000000}, ledr = 0; pulse rst_n low mid-press → count stays 0, no event after release.
- KEY0 low at edge E, held 20 cycles, sw = 0 → count = 1 exactly at edge E+7, ledr[9] high for 1 cycle; hex digit 0 = 7'b1111001; no second increment while held.
- KEY0 bounce (low 3 cycles, high 1, low 2, high) → count unchanged; then a clean press → count increments once.
- sw = 8'hFE with sw[8] = 1, press KEY1, then KEY0 twice → count 0xFE, 0xFF, 0x00, ledr[8] = 1; hex after load shows "FE" (7'b0001110, 7'b0000110).
- sw[8] = 0, sw[9] = 1, count 0, press KEY0 → count stays 0, ledr[8] = 1; press KEY2 → ledr[8] = 0.
- KEY2 and KEY1 pressed in the same cycle with count = 5 → count = 0 (clear wins); KEY1 and KEY0 pressed together with sw = 8'h10 → count = 0x10.
